mem_port_arbiter: RTL and testbench

//  Shares the single external cache-line memory port between NREQ cache-side requesters:
//  0=L1D, 1=L1I, 2=prefetch/walker. One transaction is outstanding at a time.

---
 rtl/mem_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares the single external cache-line memory port between NREQ cache-side
// requesters (0=L1D, 1=L1I, 2=prefetch/walker). Only one memory transaction is
// outstanding at a time. Incoming requests are folded into a pending set,
// granted round-robin, captured into output registers and presented to memory
// with a valid/ack handshake. The single response is steered back to the
// requester that owns the transaction. Load data is not routed here.
//
// Ports
//   clk, reset            clock (rising edge) and asynchronous active-low reset
//   req_valid[NREQ]       per-requester request pulse/level
//   req_addr/store_data/tag/opcode   packed per-requester fields, slice i = requester i
//   req_ack[NREQ]         combinational one-hot pulse: request i captured this cycle
//   rsp_valid[NREQ]       combinational one-hot pulse: response for requester i
//   mem_req_*             registered request to memory (valid, addr, data, tag, opcode, insn)
//   mem_req_ack           memory accepted the request
//   mem_rsp_valid/tag     memory response and its tag
//   busy                  a transaction is in flight
//   owner                 requester index of the current/last grant
//   err_timeout           sticky: no response within TIMEOUT busy cycles
//   err_proto             sticky: response before ack, or response tag mismatch
module mem_port_arbiter #(
  parameter int NREQ    = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 128,
  parameter int TAG_W   = 2,
  parameter int OPC_W   = 5,
  parameter int INSN_ID = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*ADDR_W-1:0]  req_addr,
  input  logic [NREQ*DATA_W-1:0]  req_store_data,
  input  logic [NREQ*TAG_W-1:0]   req_tag,
  input  logic [NREQ*OPC_W-1:0]   req_opcode,
  output logic [NREQ-1:0]         req_ack,
  output logic [NREQ-1:0]         rsp_valid,
  output logic                    mem_req_valid,
  output logic [ADDR_W-1:0]       mem_req_addr,
  output logic [DATA_W-1:0]       mem_req_store_data,
  output logic [TAG_W-1:0]        mem_req_tag,
  output logic [OPC_W-1:0]        mem_req_opcode,
  output logic                    mem_req_insn,
  input  logic                    mem_req_ack,
  input  logic                    mem_rsp_valid,
  input  logic [TAG_W-1:0]        mem_rsp_tag,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    err_timeout,
  output logic                    err_proto
);

  localparam int OW   = $clog2(NREQ);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [NREQ-1:0] REQ_ONE = NREQ'(1'b1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [NREQ-1:0]     pending_r;
  logic [NREQ-1:0]     n_pending_s;
  logic [OW-1:0]       rr_ptr_r;
  logic [OW-1:0]       owner_r;
  logic [OW-1:0]       gnt_s;
  logic                gnt_valid_s;
  logic [NREQ-1:0]     gnt_onehot_s;
  logic                grant_fire_s;
  logic                rsp_fire_s;
  logic                proto_err_s;

  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic [TAG_W-1:0]    sel_tag_s;
  logic [OPC_W-1:0]    sel_opc_s;

  logic                mem_req_valid_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   data_r;
  logic [TAG_W-1:0]    tag_r;
  logic [OPC_W-1:0]    opc_r;
  logic                insn_r;
  logic [WD_W-1:0]     wd_r;
  logic                err_timeout_r;
  logic                err_proto_r;

  // Pending set seen this cycle; forced empty while reset is held so no ack leaks out
  always_comb begin
    n_pending_s = '0;
    if (reset) begin
      n_pending_s = pending_r | req_valid;
    end else begin
      n_pending_s = '0;
    end
  end

  // Round-robin pick: first pending index at or above rr_ptr, else wrap to the lowest
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_s       = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_valid_s && n_pending_s[i] && (OW'(i) >= rr_ptr_r)) begin
        gnt_valid_s = 1'b1;
        gnt_s       = OW'(i);
      end else begin
        gnt_s = gnt_s;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_valid_s && n_pending_s[i]) begin
        gnt_valid_s = 1'b1;
        gnt_s       = OW'(i);
      end else begin
        gnt_s = gnt_s;
      end
    end
  end

  // Select the winning requester's fields for capture
  always_comb begin
    sel_addr_s = '0;
    sel_data_s = '0;
    sel_tag_s  = '0;
    sel_opc_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_s == OW'(i)) begin
        sel_addr_s = req_addr[i*ADDR_W +: ADDR_W];
        sel_data_s = req_store_data[i*DATA_W +: DATA_W];
        sel_tag_s  = req_tag[i*TAG_W +: TAG_W];
        sel_opc_s  = req_opcode[i*OPC_W +: OPC_W];
      end else begin
        sel_addr_s = sel_addr_s;
      end
    end
  end

  // FSM next state plus the combinational ack/response pulses and fault detection
  always_comb begin
    state_s      = state_r;
    grant_fire_s = 1'b0;
    rsp_fire_s   = 1'b0;
    proto_err_s  = 1'b0;
    gnt_onehot_s = REQ_ONE << gnt_s;
    req_ack      = '0;
    rsp_valid    = '0;
    case (state_r)
      IDLE: begin
        if (gnt_valid_s) begin
          grant_fire_s = 1'b1;
          req_ack      = gnt_onehot_s;
          state_s      = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        // Ack and response together: the ack is taken first, then the response completes
        if (mem_req_ack && mem_rsp_valid) begin
          rsp_fire_s = 1'b1;
          state_s    = IDLE;
        end else if (mem_req_ack) begin
          state_s = WAIT_RSP;
        end else if (mem_rsp_valid) begin
          // Response for a request memory never accepted: flag and drop it
          proto_err_s = 1'b1;
          state_s     = ISSUE;
        end else begin
          state_s = ISSUE;
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          rsp_fire_s = 1'b1;
          state_s    = IDLE;
        end else begin
          state_s = WAIT_RSP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    // A wrong tag is reported but the response is still delivered to the owner
    if (rsp_fire_s) begin
      rsp_valid = REQ_ONE << owner_r;
      if (mem_rsp_tag != tag_r) begin
        proto_err_s = 1'b1;
      end else begin
        proto_err_s = proto_err_s;
      end
    end else begin
      rsp_valid = '0;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Pending set, round-robin pointer, owner and the captured request fields
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_r <= '0;
      rr_ptr_r  <= '0;
      owner_r   <= '0;
      addr_r    <= '0;
      data_r    <= '0;
      tag_r     <= '0;
      opc_r     <= '0;
      insn_r    <= 1'b0;
    end else if (grant_fire_s) begin
      pending_r <= n_pending_s & ~gnt_onehot_s;
      owner_r   <= gnt_s;
      rr_ptr_r  <= (gnt_s == OW'(NREQ - 1)) ? OW'(0) : gnt_s + OW'(1);
      addr_r    <= sel_addr_s;
      data_r    <= sel_data_s;
      tag_r     <= sel_tag_s;
      opc_r     <= sel_opc_s;
      insn_r    <= (gnt_s == OW'(INSN_ID));
    end else begin
      // Requests arriving while busy (including from the owner) wait here
      pending_r <= n_pending_s;
    end
  end

  // Memory request valid: raised by a grant, dropped once memory acknowledges
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req_valid_r <= 1'b0;
    end else if (grant_fire_s) begin
      mem_req_valid_r <= 1'b1;
    end else if ((state_r == ISSUE) && mem_req_ack) begin
      mem_req_valid_r <= 1'b0;
    end else begin
      mem_req_valid_r <= mem_req_valid_r;
    end
  end

  // Watchdog counter: restarts on each issue, counts busy cycles, saturates
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_r <= '0;
    end else if (grant_fire_s) begin
      wd_r <= '0;
    end else if ((state_r != IDLE) && (wd_r != WD_MAX)) begin
      wd_r <= wd_r + WD_W'(1);
    end else begin
      wd_r <= wd_r;
    end
  end

  // Sticky error flags; the watchdog only reports, the FSM keeps waiting
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_timeout_r <= 1'b0;
      err_proto_r   <= 1'b0;
    end else begin
      err_proto_r <= err_proto_r | proto_err_s;
      // wd_r holds the number of busy cycles already completed before this one
      if ((state_r != IDLE) && !rsp_fire_s && (wd_r >= WD_LAST)) begin
        err_timeout_r <= 1'b1;
      end else begin
        err_timeout_r <= err_timeout_r;
      end
    end
  end

  assign mem_req_valid      = mem_req_valid_r;
  assign mem_req_addr       = addr_r;
  assign mem_req_store_data = data_r;
  assign mem_req_tag        = tag_r;
  assign mem_req_opcode     = opc_r;
  assign mem_req_insn       = insn_r;
  assign busy               = (state_r != IDLE);
  assign owner              = owner_r;
  assign err_timeout        = err_timeout_r;
  assign err_proto          = err_proto_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter (NREQ=3, TIMEOUT=16). A transaction-level
// model (pending set, next-in-turn pointer, in-flight transaction record) predicts
// every output each cycle; directed sequences add hand-computed literal checks.
module tb_mem_port_arbiter;

  localparam int NREQ    = 3;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 128;
  localparam int TAG_W   = 2;
  localparam int OPC_W   = 5;
  localparam int INSN_ID = 1;
  localparam int TIMEOUT = 16;

  logic                   clk;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_store_data;
  logic [NREQ*TAG_W-1:0]  req_tag;
  logic [NREQ*OPC_W-1:0]  req_opcode;
  logic [NREQ-1:0]        req_ack;
  logic [NREQ-1:0]        rsp_valid;
  logic                   mem_req_valid;
  logic [ADDR_W-1:0]      mem_req_addr;
  logic [DATA_W-1:0]      mem_req_store_data;
  logic [TAG_W-1:0]       mem_req_tag;
  logic [OPC_W-1:0]       mem_req_opcode;
  logic                   mem_req_insn;
  logic                   mem_req_ack;
  logic                   mem_rsp_valid;
  logic [TAG_W-1:0]       mem_rsp_tag;
  logic                   busy;
  logic [1:0]             owner;
  logic                   err_timeout;
  logic                   err_proto;

  mem_port_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
    .OPC_W(OPC_W), .INSN_ID(INSN_ID), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_store_data(req_store_data),
    .req_tag(req_tag), .req_opcode(req_opcode),
    .req_ack(req_ack), .rsp_valid(rsp_valid),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
    .mem_req_store_data(mem_req_store_data), .mem_req_tag(mem_req_tag),
    .mem_req_opcode(mem_req_opcode), .mem_req_insn(mem_req_insn),
    .mem_req_ack(mem_req_ack), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_tag(mem_rsp_tag),
    .busy(busy), .owner(owner), .err_timeout(err_timeout), .err_proto(err_proto)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit                m_busy, m_acked, m_errp, m_errt;
  bit [NREQ-1:0]     m_pend;
  int                m_next, m_owner, m_age;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  logic [TAG_W-1:0]  m_tag;
  logic [OPC_W-1:0]  m_opc;

  always @(negedge clk) begin
    logic [NREQ-1:0] e_ack, e_rsp, np;
    int g;
    bit got;
    e_ack = '0;
    e_rsp = '0;
    g     = -1;
    got   = 1'b0;
    if (!reset) begin
      m_busy = 1'b0; m_acked = 1'b0; m_errp = 1'b0; m_errt = 1'b0;
      m_pend = '0; m_next = 0; m_owner = 0; m_age = 0;
      m_addr = '0; m_data = '0; m_tag = '0; m_opc = '0;
    end
    chk("m_busy",      128'(busy),               128'(m_busy));
    chk("m_owner",     128'(owner),              128'(m_owner));
    chk("m_req_valid", 128'(mem_req_valid),      128'(m_busy && !m_acked));
    chk("m_addr",      128'(mem_req_addr),       128'(m_addr));
    chk("m_data",      128'(mem_req_store_data), 128'(m_data));
    chk("m_tag",       128'(mem_req_tag),        128'(m_tag));
    chk("m_opcode",    128'(mem_req_opcode),     128'(m_opc));
    chk("m_insn",      128'(mem_req_insn),       128'(m_owner == INSN_ID));
    chk("m_err_proto", 128'(err_proto),          128'(m_errp));
    chk("m_err_tmo",   128'(err_timeout),        128'(m_errt));
    if (reset) begin
      np = m_pend | req_valid;
      if (!m_busy) begin
        for (int k = 0; k < NREQ; k++) begin
          if (g < 0 && np[(m_next + k) % NREQ]) g = (m_next + k) % NREQ;
        end
        if (g >= 0) begin
          e_ack[g] = 1'b1;
          np[g]    = 1'b0;
          m_busy   = 1'b1;
          m_acked  = 1'b0;
          m_owner  = g;
          m_next   = (g + 1) % NREQ;
          m_age    = 0;
          m_addr   = req_addr[g*ADDR_W +: ADDR_W];
          m_data   = req_store_data[g*DATA_W +: DATA_W];
          m_tag    = req_tag[g*TAG_W +: TAG_W];
          m_opc    = req_opcode[g*OPC_W +: OPC_W];
        end
      end else begin
        if (!m_acked) begin
          if (mem_req_ack) begin
            m_acked = 1'b1;
            got     = mem_rsp_valid;
          end else if (mem_rsp_valid) begin
            m_errp = 1'b1;
          end
        end else begin
          got = mem_rsp_valid;
        end
        if (got) begin
          e_rsp[m_owner] = 1'b1;
          if (mem_rsp_tag != m_tag) m_errp = 1'b1;
          m_busy = 1'b0;
        end else begin
          m_age++;
          if (m_age >= TIMEOUT) m_errt = 1'b1;
        end
      end
      m_pend = np;
    end
    chk("m_req_ack",   128'(req_ack),   128'(e_ack));
    chk("m_rsp_valid", 128'(rsp_valid), 128'(e_rsp));
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic [NREQ-1:0] rv, input logic mack, input logic mrsp,
                     input logic [TAG_W-1:0] mtag);
    @(posedge clk);
    #1;
    req_valid     = rv;
    mem_req_ack   = mack;
    mem_rsp_valid = mrsp;
    mem_rsp_tag   = mtag;
    #1;
  endtask

  task automatic grant(input logic [NREQ-1:0] rv, input logic [NREQ-1:0] exp_ack);
    cyc(rv, 1'b0, 1'b0, 2'd0);
    chk("grant_ack", 128'(req_ack), 128'(exp_ack));
  endtask

  task automatic xact(input int o, input logic insn, input logic [TAG_W-1:0] tag);
    cyc(3'b000, 1'b1, 1'b0, 2'd0);
    chk("xact_owner", 128'(owner), 128'(o));
    chk("xact_insn",  128'(mem_req_insn), 128'(insn));
    chk("xact_valid", 128'(mem_req_valid), 128'(1'b1));
    cyc(3'b000, 1'b0, 1'b1, tag);
    chk("xact_rsp", 128'(rsp_valid), 128'(3'b001 << o));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid = '0; mem_req_ack = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_tag = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    req_valid = '0; mem_req_ack = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_tag = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*ADDR_W +: ADDR_W]       = 32'h1000_0000 + 32'(i * 64);
      req_store_data[i*DATA_W +: DATA_W] = {4{32'hA5A5_0000 + 32'(i)}};
      req_tag[i*TAG_W +: TAG_W]          = 2'(i + 1);
      req_opcode[i*OPC_W +: OPC_W]       = 5'(i * 3 + 1);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   128'(busy), 128'(1'b0));
    chk("rst_owner",  128'(owner), 128'(2'd0));
    chk("rst_mvalid", 128'(mem_req_valid), 128'(1'b0));
    chk("rst_errs",   128'({err_timeout, err_proto}), 128'(2'b00));
    reset = 1'b1;

    // 1. single L1D load: ack at t2, response at t5
    cyc(3'b001, 1'b0, 1'b0, 2'd0);
    chk("t1_ack_t0", 128'(req_ack), 128'(3'b001));
    cyc(3'b000, 1'b0, 1'b0, 2'd0);
    chk("t1_valid_t1", 128'(mem_req_valid), 128'(1'b1));
    chk("t1_addr", 128'(mem_req_addr), 128'(32'h1000_0000));
    chk("t1_tag",  128'(mem_req_tag), 128'(2'd1));
    cyc(3'b000, 1'b1, 1'b0, 2'd0);
    chk("t1_valid_t2", 128'(mem_req_valid), 128'(1'b1));
    cyc(3'b000, 1'b0, 1'b0, 2'd0);
    chk("t1_valid_t3", 128'(mem_req_valid), 128'(1'b0));
    chk("t1_busy_t3",  128'(busy), 128'(1'b1));
    cyc(3'b000, 1'b0, 1'b0, 2'd0);
    cyc(3'b000, 1'b0, 1'b1, 2'd1);
    chk("t1_rsp_t5", 128'(rsp_valid), 128'(3'b001));
    cyc(3'b000, 1'b0, 1'b0, 2'd0);
    chk("t1_busy_t6", 128'(busy), 128'(1'b0));

    // 2. all three at once from reset: order 0,1,2; insn only on the second
    do_reset();
    grant(3'b111, 3'b001);
    xact(0, 1'b0, 2'd1);
    grant(3'b000, 3'b010);
    xact(1, 1'b1, 2'd2);
    grant(3'b000, 3'b100);
    xact(2, 1'b0, 2'd3);
    cyc(3'b000, 1'b0, 1'b0, 2'd0);
    chk("t2_idle", 128'(busy), 128'(1'b0));

    // 3. round-robin skip with rr_ptr=2 and pending=011; repeats absorbed
    grant(3'b010, 3'b010);
    cyc(3'b011, 1'b1, 1'b0, 2'd0);
    cyc(3'b011, 1'b0, 1'b0, 2'd0);
    cyc(3'b000, 1'b0, 1'b1, 2'd2);
    chk("t3_rsp1", 128'(rsp_valid), 128'(3'b010));
    grant(3'b000, 3'b001);
    xact(0, 1'b0, 2'd1);
    grant(3'b000, 3'b010);
    xact(1, 1'b1, 2'd2);
    cyc(3'b000, 1'b0, 1'b0, 2'd0);
    chk("t3_no_double", 128'({busy, req_ack}), 128'(4'b0000));
    grant(3'b111, 3'b100);
    xact(2, 1'b0, 2'd3);
    grant(3'b000, 3'b001);
    xact(0, 1'b0, 2'd1);
    grant(3'b000, 3'b010);
    xact(1, 1'b1, 2'd2);
    cyc(3'b000, 1'b0, 1'b0, 2'd0);

    // 4. protocol faults: response before ack, then tag 3 vs captured 1
    chk("t4_proto_clear", 128'(err_proto), 128'(1'b0));
    grant(3'b001, 3'b001);
    cyc(3'b000, 1'b0, 1'b1, 2'd1);
    chk("t4_dropped", 128'(rsp_valid), 128'(3'b000));
    cyc(3'b000, 1'b0, 1'b0, 2'd0);
    chk("t4_proto_set", 128'({err_proto, busy, mem_req_valid}), 128'(3'b111));
    cyc(3'b000, 1'b1, 1'b0, 2'd0);
    cyc(3'b000, 1'b0, 1'b1, 2'd3);
    chk("t4_bad_tag_rsp", 128'(rsp_valid), 128'(3'b001));
    repeat (3) cyc(3'b000, 1'b0, 1'b0, 2'd0);
    chk("t4_sticky", 128'({err_proto, busy}), 128'(2'b10));

    // 5. watchdog: flag appears 16 cycles after issue, late response still completes
    do_reset();
    chk("t5_cleared", 128'({err_proto, err_timeout}), 128'(2'b00));
    grant(3'b100, 3'b100);
    cyc(3'b000, 1'b1, 1'b0, 2'd0);
    chk("t5_tmo_k0", 128'(err_timeout), 128'(1'b0));
    for (int k = 1; k <= 17; k++) begin
      cyc(3'b000, 1'b0, 1'b0, 2'd0);
      chk("t5_tmo_k", 128'(err_timeout), 128'(k >= 16));
    end
    cyc(3'b000, 1'b0, 1'b1, 2'd3);
    chk("t5_late_rsp", 128'(rsp_valid), 128'(3'b100));
    cyc(3'b000, 1'b0, 1'b0, 2'd0);
    chk("t5_idle", 128'({busy, err_timeout}), 128'(2'b01));

    // 6. reset during WAIT_RSP with requester 2 pending
    grant(3'b001, 3'b001);
    cyc(3'b100, 1'b1, 1'b0, 2'd0);
    cyc(3'b000, 1'b0, 1'b0, 2'd0);
    chk("t6_waiting", 128'(busy), 128'(1'b1));
    #1;
    reset = 1'b0;
    req_valid = 3'b100;
    #1;
    chk("t6_zero_ctrl", 128'({busy, mem_req_valid, owner, err_timeout, err_proto, mem_req_insn}), 128'(7'd0));
    chk("t6_zero_pulse", 128'({req_ack, rsp_valid}), 128'(6'd0));
    chk("t6_zero_addr", 128'(mem_req_addr), 128'(32'd0));
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) begin
      cyc(3'b000, 1'b0, 1'b0, 2'd0);
      chk("t6_no_grant", 128'({busy, req_ack}), 128'(4'b0000));
    end
    grant(3'b010, 3'b010);
    xact(1, 1'b1, 2'd2);
    cyc(3'b000, 1'b0, 1'b0, 2'd0);
    cyc(3'b000, 1'b0, 1'b0, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
